muldiv_sched: RTL
=================

// Module: muldiv_sched
// PURPOSE
//  EX-stage controller for the shared M-extension units: one external multiplier and one external iterative divider.
//  Accepts one MUL/DIV op from EX and decodes funct3 into mul_type_t / div_type_t. Launches the correct unit.
//  Stalls the pipeline until the result returns. Resolves RISC-V divide corner cases without launching the divider.
// PARAMETERS
//  XLEN         32  operand/result width
//  WDOG_CYCLES  64  max wait for unit done before error abort; 0 disables the watchdog
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       asynchronous active-low reset
//  flush       in   1       kill in-flight op (branch mispredict)
//  req_valid   in   1       EX holds an M op; held until resp_valid or flush
//  req_funct3  in   3       000 mul,001 mulh,010 mulhsu,011 mulhu,100 div,101 divu,110 rem,111 remu
//  req_a       in   XLEN    rs1 value
//  req_b       in   XLEN    rs2 value
//  stall       out  1       req_valid & ~resp_valid
//  resp_valid  out  1       1-cycle result pulse
//  resp_data   out  XLEN    result
//  resp_err    out  1       with resp_valid: watchdog expired, resp_data=0
//  mul_start   out  1       1-cycle launch pulse to multiplier
//  mul_type    out  2       uu_mul/ss_mul/su_mul
//  div_start   out  1       1-cycle launch pulse to divider
//  div_abort   out  1       1-cycle divider kill
//  div_type    out  2       ss_div/uu_div/ss_rem/uu_rem
//  unit_a      out  XLEN    registered operand A to both units
//  unit_b      out  XLEN    registered operand B to both units
//  mul_done    in   1       multiplier product valid
//  mul_p       in   2*XLEN  product
//  div_done    in   1       divider result valid
//  div_q       in   XLEN    quotient
//  div_r       in   XLEN    remainder
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0. Watchdog counter 0. Fuse cache invalid.
//  FSM states: IDLE, MUL_WAIT, DIV_WAIT, DONE.
//  IDLE, req_valid & ~flush at edge t: latch funct3, a, b into unit_a/unit_b. Then:
//   mul ops -> MUL_WAIT, mul_start=1 during cycle t+1.
//    Type map: mul->uu_mul, mulh->ss_mul, mulhsu->su_mul, mulhu->uu_mul.
//   div/rem with b==0 -> DONE. div/divu give all-ones; rem/remu give a.
//   div/rem with signed overflow (a=0x80000000, b=-1) -> DONE. div gives 0x80000000; rem gives 0.
//   otherwise -> DIV_WAIT, div_start=1 during cycle t+1.
//  MUL_WAIT: on mul_done capture result -> DONE. mul takes mul_p[XLEN-1:0]; mulh/mulhsu/mulhu take mul_p[2*XLEN-1:XLEN].
//  DIV_WAIT: on div_done capture result -> DONE. div/divu take div_q; rem/remu take div_r.
//  *_start fires only on the cycle after entering a WAIT state, never again for that op.
//  DONE: resp_valid=1 for one cycle with registered resp_data. Next state IDLE.
//   A new req_valid can be accepted on the cycle after DONE.
//  Latency, req accept to resp_valid:
//   corner-case shortcut: 2 cycles.
//   unit op: done arrives N cycles after start -> N+2 cycles.
//  done inputs are ignored outside the matching WAIT state. A mul_done/div_done in IDLE or DONE is dropped.
//  flush in MUL_WAIT/DIV_WAIT -> IDLE next cycle, no resp_valid.
//   DIV_WAIT flush also pulses div_abort=1.
//   Any mul_done arriving later is ignored.
//  flush in DONE suppresses resp_valid. flush has priority over a same-cycle done.
//  Watchdog: counts cycles in a WAIT state and resets on state entry.
//   When the count reaches WDOG_CYCLES: resp_err=1, resp_data=0, div_abort pulsed if dividing, then DONE.
//  rst_n low at any time forces IDLE immediately. No start/abort pulse is issued during or after reset.
// CONFIGURATION
//  MULDIV_FUSE_EN defined:
//   Keep a 1-entry cache {valid, a, b, signed, q, r}. It fills on every normal div_done.
//   A div/rem request that hits (same a, b, signedness) goes IDLE->DONE with the cached q or r and no div_start.
//   Hit latency is 2 cycles.
//   Shortcut results never fill the cache. Flush does not invalidate it; reset does.
//  MULDIV_FUSE_EN undefined: no cache. Every non-corner div/rem launches the divider.
// TESTING
//  mulhu a=0xFFFFFFFF b=0xFFFFFFFF, mul_done 3 cycles after start -> resp_data=0xFFFFFFFE at accept+5, stall until then
//  div a=0x80000000 b=0xFFFFFFFF -> no div_start, resp_data=0x80000000 at accept+2; remu a=7 b=0 -> resp_data=7
//  divu 100/7 then remu 100/7 -> results 14, 2
//   FUSE_EN: second op has no div_start, 2-cycle latency; without FUSE_EN: second div_start issued
//  div in flight, flush 2 cycles after start -> div_abort pulse, no resp_valid
//   late div_done ignored; next mul completes correctly
//  divider never returns, WDOG_CYCLES=64 -> resp_valid with resp_err=1, resp_data=0, div_abort
//   all occur 64 cycles after DIV_WAIT entry
//  rst_n dropped mid-MUL_WAIT -> all outputs 0 asynchronously; post-reset mul_done produces no resp_valid

Source files
------------

// File: rtl/muldiv_sched.sv
// muldiv_sched: EX-stage scheduler for the shared multiplier and iterative divider.
// Define MULDIV_FUSE_EN to add a 1-entry divide result cache that skips repeated divides.
module muldiv_sched #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_err,
  output logic              mul_start,
  output logic [1:0]        mul_type,
  output logic              div_start,
  output logic              div_abort,
  output logic [1:0]        div_type,
  output logic [XLEN-1:0]   unit_a,
  output logic [XLEN-1:0]   unit_b,
  input  logic              mul_done,
  input  logic [2*XLEN-1:0] mul_p,
  input  logic              div_done,
  input  logic [XLEN-1:0]   div_q,
  input  logic [XLEN-1:0]   div_r
);

  typedef enum logic [1:0] {StIdle, StMulWait, StDivWait, StDone} state_e;
  typedef enum logic [1:0] {UuMul = 2'd0, SsMul = 2'd1, SuMul = 2'd2} mul_type_e;
  typedef enum logic [1:0] {SsDiv = 2'd0, UuDiv = 2'd1, SsRem = 2'd2, UuRem = 2'd3} div_type_e;

  localparam int unsigned CntW = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES + 1);
  localparam logic [CntW-1:0] WdogLast = CntW'((WDOG_CYCLES == 0) ? 0 : WDOG_CYCLES - 1);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] res_q;
  logic            err_q;
  logic [CntW-1:0] cnt_q;

  logic            req_is_div;
  logic            req_signed;
  logic            req_is_rem;
  logic            b_zero;
  logic            ovf;
  logic            corner;
  logic [XLEN-1:0] corner_res;
  mul_type_e       mul_type_d;
  div_type_e       div_type_d;
  logic            wdog_hit;
  logic            fuse_hit;
  logic [XLEN-1:0] fuse_res;

  assign stall    = req_valid & ~resp_valid;
  assign wdog_hit = (WDOG_CYCLES != 0) && (cnt_q == WdogLast);

  // Request decode and RISC-V divide corner cases, resolved without the divider.
  always_comb begin
    req_is_div = req_funct3[2];
    req_signed = ~req_funct3[0];
    req_is_rem = req_funct3[1];
    b_zero     = (req_b == '0);
    ovf        = req_signed && (req_a == MinInt) && (req_b == {XLEN{1'b1}});
    corner     = req_is_div && (b_zero || ovf);
    if (b_zero) begin
      corner_res = req_is_rem ? req_a : {XLEN{1'b1}};
    end else begin
      corner_res = req_is_rem ? '0 : MinInt;
    end
    unique case (req_funct3[1:0])
      2'b00:   mul_type_d = UuMul;
      2'b01:   mul_type_d = SsMul;
      2'b10:   mul_type_d = SuMul;
      2'b11:   mul_type_d = UuMul;
      default: mul_type_d = UuMul;
    endcase
    unique case (req_funct3[1:0])
      2'b00:   div_type_d = SsDiv;
      2'b01:   div_type_d = UuDiv;
      2'b10:   div_type_d = SsRem;
      2'b11:   div_type_d = UuRem;
      default: div_type_d = SsDiv;
    endcase
  end

`ifdef MULDIV_FUSE_EN
  logic            c_valid;
  logic            c_signed;
  logic [XLEN-1:0] c_a;
  logic [XLEN-1:0] c_b;
  logic [XLEN-1:0] c_q;
  logic [XLEN-1:0] c_r;

  // Filled only by a divide that really ran; flush leaves the entry intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid  <= 1'b0;
      c_signed <= 1'b0;
      c_a      <= '0;
      c_b      <= '0;
      c_q      <= '0;
      c_r      <= '0;
    end else if (state_q == StDivWait && div_done && !flush) begin
      c_valid  <= 1'b1;
      c_signed <= ~f3_q[0];
      c_a      <= unit_a;
      c_b      <= unit_b;
      c_q      <= div_q;
      c_r      <= div_r;
    end
  end

  always_comb begin
    fuse_hit = c_valid && (c_a == req_a) && (c_b == req_b) && (c_signed == req_signed);
    fuse_res = req_is_rem ? c_r : c_q;
  end
`else
  assign fuse_hit = 1'b0;
  assign fuse_res = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      f3_q       <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      mul_start  <= 1'b0;
      mul_type   <= '0;
      div_start  <= 1'b0;
      div_abort  <= 1'b0;
      div_type   <= '0;
      unit_a     <= '0;
      unit_b     <= '0;
    end else begin
      mul_start  <= 1'b0;
      div_start  <= 1'b0;
      div_abort  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      unique case (state_q)
        StIdle: begin
          if (req_valid && !flush) begin
            f3_q   <= req_funct3;
            unit_a <= req_a;
            unit_b <= req_b;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            if (!req_is_div) begin
              mul_type  <= mul_type_d;
              mul_start <= 1'b1;
              state_q   <= StMulWait;
            end else begin
              div_type <= div_type_d;
              if (corner) begin
                res_q   <= corner_res;
                state_q <= StDone;
              end else if (fuse_hit) begin
                res_q   <= fuse_res;
                state_q <= StDone;
              end else begin
                div_start <= 1'b1;
                state_q   <= StDivWait;
              end
            end
          end
        end
        StMulWait: begin
          if (flush) begin
            state_q <= StIdle;
          end else if (mul_done) begin
            res_q   <= (f3_q[1:0] == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
            state_q <= StDone;
          end else if (wdog_hit) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDivWait: begin
          if (flush) begin
            div_abort <= 1'b1;
            state_q   <= StIdle;
          end else if (div_done) begin
            res_q   <= f3_q[1] ? div_r : div_q;
            state_q <= StDone;
          end else if (wdog_hit) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          // A timed-out divider is killed even when the response itself is flushed.
          div_abort <= err_q & f3_q[2];
          if (!flush) begin
            resp_valid <= 1'b1;
            resp_err   <= err_q;
            resp_data  <= res_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
